sevenseg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-segment, multi-digit 7-segment display.

---
 rtl/sevenseg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for a common-segment, multi-digit
//   7-segment display. Each digit gets a blanking interval (all digits off)
//   followed by a dwell interval in which that digit alone is driven. One
//   shared segment decoder serves every digit.
//
//   New digit codes arrive over a valid/ready handshake into a single pending
//   buffer. The buffer is copied to the displayed (active) register only at a
//   frame boundary, so a frame is never shown with a mix of old and new codes.
//
//   Optional build macro: SEVENSEG_SCAN_HEX_EN
//     defined   -> codes 10..15 show hex glyphs A b C d E F
//     undefined -> codes 10..15 leave the digit dark while it is still scanned
// -----------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   upd_data,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_start
);

    // ------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Shared segment decoder, active-low, bit 6 = segment a
    // ------------------------------------------------------------------
    function automatic logic [6:0] dec(input logic [3:0] code);
        logic [6:0] glyph;
        glyph = SEG_OFF;
        case (code)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
`ifdef SEVENSEG_SCAN_HEX_EN
            4'd10:   glyph = 7'b0001000;
            4'd11:   glyph = 7'b1100000;
            4'd12:   glyph = 7'b0110001;
            4'd13:   glyph = 7'b1000010;
            4'd14:   glyph = 7'b0110000;
            4'd15:   glyph = 7'b0111000;
`endif
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

    // One-hot digit enable for a given scan index
    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            vec[i] = (idx == IDX_W'(i));
        end
        return vec;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [IDX_W-1:0]         idx_r;

    logic [4*NUM_DIGITS-1:0]  active_r;
    logic [4*NUM_DIGITS-1:0]  pending_r;
    logic                     pending_full_r;

    logic [6:0]               seg_r;
    logic [NUM_DIGITS-1:0]    digit_en_r;
    logic                     frame_start_r;

    // Next-state / next-output signals
    state_t                   state_s;
    logic [CNT_W-1:0]         cnt_s;
    logic [IDX_W-1:0]         idx_s;
    logic                     boundary_s;
    logic                     xfer_s;
    logic [3:0]               code_s;
    logic [6:0]               seg_s;
    logic [NUM_DIGITS-1:0]    digit_en_s;

    // Scan FSM next state: blank interval, then dwell, then move to next digit
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + CNT_W'(1);
        idx_s      = idx_r;
        boundary_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_SHOW;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    state_s    = ST_BLANK;
                    cnt_s      = '0;
                    boundary_s = (idx_r == LAST_IDX);
                    idx_s      = (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
                end else begin
                    state_s = ST_SHOW;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = '0;
                idx_s   = '0;
            end
        endcase
    end

    // Select the code of the digit about to be shown; active is stable on
    // every SHOW entry because it only changes when leaving SHOW
    always_comb begin
        code_s = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            code_s = (idx_s == IDX_W'(i)) ? active_r[4*i +: 4] : code_s;
        end
    end

    // Output values for the state being entered, so registered outputs are
    // already correct on the first cycle of each state
    always_comb begin
        seg_s      = SEG_OFF;
        digit_en_s = '0;
        if (state_s == ST_SHOW) begin
            seg_s      = dec(code_s);
            digit_en_s = onehot(idx_s);
        end else begin
            seg_s      = SEG_OFF;
            digit_en_s = '0;
        end
    end

    // A transfer happens only while the pending buffer is empty
    always_comb begin
        xfer_s = upd_valid & ~pending_full_r;
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BLANK;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
        end
    end

    // Pending buffer fill and frame-boundary copy into the active register.
    // A transfer and a copy never coincide: a transfer needs an empty buffer,
    // a copy needs a full one. A transfer on a boundary cycle therefore waits
    // for the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r       <= {NUM_DIGITS{4'hF}};
            pending_r      <= '0;
            pending_full_r <= 1'b0;
        end else begin
            if (boundary_s && pending_full_r) begin
                active_r       <= pending_r;
                pending_full_r <= 1'b0;
            end else if (xfer_s) begin
                pending_r      <= upd_data;
                pending_full_r <= 1'b1;
            end else begin
                pending_full_r <= pending_full_r;
            end
        end
    end

    // Registered display outputs and frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r         <= SEG_OFF;
            digit_en_r    <= '0;
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_s;
            digit_en_r    <= digit_en_s;
            frame_start_r <= boundary_s;
        end
    end

    assign seg         = seg_r;
    assign digit_en    = digit_en_r;
    assign frame_start = frame_start_r;
    assign upd_ready   = ~pending_full_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
//   Directed plus random stimulus for sevenseg_scan_ctrl (4 digits, dwell 8,
//   blank 2). Expected outputs come from a frame-position model: the cycle
//   number since reset release fixes which digit is blanking or showing, and
//   a small active/pending model tracks what each digit should display.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT;

    logic            clk;
    logic            rst;
    logic [4*ND-1:0] upd_data;
    logic            upd_valid;
    logic            upd_ready;
    logic [6:0]      seg;
    logic [ND-1:0]   digit_en;
    logic            frame_start;

    int total;
    int bad;

    // reference model state
    int          n;          // rising edges since reset release
    logic [3:0]  m_act [ND];
    logic [15:0] m_pend;
    bit          m_pfull;
    bit          m_xfer;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_data   (upd_data),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .seg        (seg),
        .digit_en   (digit_en),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] tbl [16];
        tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010;
        tbl[3]  = 7'b0000110; tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100;
        tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111; tbl[8]  = 7'b0000000;
        tbl[9]  = 7'b0000100;
`ifdef SEVENSEG_SCAN_HEX_EN
        tbl[10] = 7'b0001000; tbl[11] = 7'b1100000; tbl[12] = 7'b0110001;
        tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
`else
        for (int k = 10; k < 16; k++) tbl[k] = 7'b1111111;
`endif
        return tbl[c];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int p, d, w;
        bit show;
        logic [ND-1:0] e_en;
        logic [6:0]    e_seg;
        p    = n % FRAME;
        d    = p / SLOT;
        w    = p % SLOT;
        show = (w >= BL);
        e_en  = show ? ND'(1 << d) : '0;
        e_seg = show ? glyph(m_act[d]) : 7'h7F;
        check({tag, "_digit_en"},    16'(digit_en),    16'(e_en));
        check({tag, "_seg"},         16'(seg),         16'(e_seg));
        check({tag, "_frame_start"}, 16'(frame_start), 16'((n > 0) && (p == 0)));
        check({tag, "_upd_ready"},   16'(upd_ready),   16'(!m_pfull));
    endtask

    task automatic model_reset();
        n       = 0;
        m_pfull = 1'b0;
        m_pend  = 16'h0000;
        m_xfer  = 1'b0;
        for (int k = 0; k < ND; k++) m_act[k] = 4'hF;
    endtask

    // one clock: model the edge, then compare on the falling edge
    task automatic tick();
        bit was_full;
        @(posedge clk);
        n++;
        was_full = m_pfull;
        m_xfer   = 1'b0;
        if ((n % FRAME == 0) && was_full) begin
            for (int k = 0; k < ND; k++) m_act[k] = m_pend[4*k +: 4];
            m_pfull = 1'b0;
        end
        if (upd_valid && !was_full) begin
            m_pend  = upd_data;
            m_pfull = 1'b1;
            m_xfer  = 1'b1;
        end
        @(negedge clk);
        check_all("run");
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // hold an offer until the model sees it transferred
    task automatic send(input logic [15:0] d);
        int budget;
        upd_valid = 1'b1;
        upd_data  = d;
        budget    = 0;
        m_xfer    = 1'b0;
        while (!m_xfer && budget < 4 * FRAME) begin
            tick();
            budget++;
        end
        if (!m_xfer) begin
            total++;
            bad++;
            $error("FAIL send_timeout data=%h waited=%0d", d, budget);
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        int guard;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_data  = 16'h0000;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_digit_en", 16'(digit_en), 16'h0000);
        check("reset_seg",      16'(seg),      16'h007F);
        check("reset_ready",    16'(upd_ready), 16'h0001);
        rst = 1'b0;
        check_all("rel");

        // 1: free-running scan, all digits blank
        idle(2 * FRAME);

        // 2: first update offered partway into a frame
        idle(5);
        send(16'h4321);
        // 3: second update while pending is full
        send(16'h9999);
        idle(2 * FRAME);

        // 4: transfer exactly on the boundary cycle
        guard = 0;
        while ((n % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        check("align_boundary", 16'(n % FRAME), 16'(FRAME - 1));
        upd_valid = 1'b1;
        upd_data  = 16'h0000;
        tick();
        check("boundary_xfer", 16'(m_xfer), 16'h0001);
        upd_valid = 1'b0;
        idle(2 * FRAME);

        // 5: asynchronous reset while digit 2 is shown, with data pending
        send(16'h5678);
        guard = 0;
        while (!(((n % FRAME) >= 2 * SLOT + BL) && ((n % FRAME) < 3 * SLOT)) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        check("pre_rst_digit2", 16'(digit_en), 16'h0004);
        rst = 1'b1;
        #1;
        check("rst_digit_en",    16'(digit_en),    16'h0000);
        check("rst_seg",         16'(seg),         16'h007F);
        check("rst_ready",       16'(upd_ready),   16'h0001);
        check("rst_frame_start", 16'(frame_start), 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("rel2");
        idle(2 * FRAME);

        // 6: hex code A on every digit, then a mixed pattern
        send(16'hAAAA);
        idle(2 * FRAME);
        send(16'hFCB0);
        idle(2 * FRAME);

        // random updates with random gaps
        for (int r = 0; r < 20; r++) begin
            idle($urandom_range(0, 50));
            send(16'($urandom));
        end
        idle(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
